// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port signal bundle for the arbiter
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_read;
    logic [WORD_SIZE-1:0] i_address;
    logic                 i_cancel;
    logic                 i_ack;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_busy;

    logic                 d_read;
    logic                 d_write;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_busy;

    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Arbiter side: serves the two requesters and drives the memory command
    modport slave (
        input  i_read, i_address, i_cancel,
        output i_ack, i_rdata, i_busy,
        input  d_read, d_write, d_address, d_wdata,
        output d_ack, d_rdata, d_busy,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Environment side: CPU requesters plus the memory
    modport master (
        output i_read, i_address, i_cancel,
        input  i_ack, i_rdata, i_busy,
        output d_read, d_write, d_address, d_wdata,
        input  d_ack, d_rdata, d_busy,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one shared memory port with fetch starvation guard
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t               state_q;
    logic [3:0]           streak_q;
    logic [3:0]           streak_d;
    logic                 drop_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [WORD_SIZE-1:0] mem_address_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;
    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic                 i_ack_q;
    logic                 d_ack_q;

    logic                 i_pending;
    logic                 d_pending;
    logic                 take_i;
    logic                 take_d;

    // Grant decision in IDLE and next value of the consecutive-data-grant streak
    always_comb begin
        i_pending = bus.i_read & ~bus.i_cancel;
        d_pending = bus.d_read | bus.d_write;
        take_d    = (state_q == IDLE) & d_pending & (~i_pending | (streak_q < STREAK_MAX));
        take_i    = (state_q == IDLE) & i_pending & ~take_d;
        streak_d  = streak_q;
        if (take_i) begin
            streak_d = 4'd0;
        end else if (take_d) begin
            if (bus.i_read) begin
                // saturate so a cancelled fetch cannot push the streak past the limit
                streak_d = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : streak_q;
            end else begin
                streak_d = 4'd0;
            end
        end
    end

    // Access sequencer: grant, wait for memory completion, one response cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            streak_q      <= 4'd0;
            drop_q        <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
        end else begin
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            streak_q <= streak_d;
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        state_q       <= BUSY_D;
                        // both strobes high means a write
                        mem_read_q    <= ~bus.d_write;
                        mem_write_q   <= bus.d_write;
                        mem_address_q <= bus.d_address;
                        mem_wdata_q   <= bus.d_wdata;
                    end else if (take_i) begin
                        state_q       <= BUSY_I;
                        mem_read_q    <= 1'b1;
                        mem_write_q   <= 1'b0;
                        mem_address_q <= bus.i_address;
                        drop_q        <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack) begin
                        mem_read_q <= 1'b0;
                        drop_q     <= 1'b0;
                        // a flush that lands on the completion cycle also discards the word
                        if (drop_q | bus.i_cancel) begin
                            state_q <= IDLE;
                        end else begin
                            i_rdata_q <= bus.mem_rdata;
                            i_ack_q   <= 1'b1;
                            state_q   <= RESP;
                        end
                    end else if (bus.i_cancel) begin
                        drop_q <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        d_rdata_q   <= bus.mem_rdata;
                        d_ack_q     <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_ack       = i_ack_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.i_busy      = bus.i_read & ~i_ack_q;
    assign bus.d_busy      = (bus.d_read | bus.d_write) & ~d_ack_q;
endmodule
